// File: rtl/cai_fetch_pkg.sv
// cai_fetch_pkg
// Types and constants of the CAI submit-ring fetch engine: FSM state
// encoding, descriptor status codes, descriptor size and the v1 header check.
// No ports (package).
package cai_fetch_pkg;

  import carbon_arch_pkg::*;

  localparam int SUBMIT_BYTES = CARBON_CAI_SUBMIT_DESC_V1_BYTES;
  localparam int SUBMIT_BITS  = SUBMIT_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    OUT   = 3'd4
  } fetch_state_e;

  localparam logic [1:0] CAI_FETCH_OK     = 2'd0;
  localparam logic [1:0] CAI_FETCH_BADHDR = 2'd1;
  localparam logic [1:0] CAI_FETCH_BUSERR = 2'd2;

  // True when the descriptor carries a well-formed v1 header.
  function automatic logic hdr_ok(input logic [SUBMIT_BITS-1:0] d);
    return (d[CARBON_CAI_SUBMIT_DESC_V1_VERSION_LSB +: 8] == CARBON_CAI_SUBMIT_DESC_V1_VERSION)
        && (d[CARBON_CAI_SUBMIT_DESC_V1_SIZE_DW_LSB +: 8] == 8'(SUBMIT_BYTES / 4))
        && (d[CARBON_CAI_SUBMIT_DESC_V1_FMT_FLAGS_LSB +: 16] == 16'h0000)
        && (d[CARBON_CAI_SUBMIT_DESC_V1_RSVD2_LSB +: 32] == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg
// Architectural constants shared across Carbon blocks. This slice holds the
// layout of the CAI v1 submit descriptor: a 32-byte little-endian record.
//   [7:0]     desc_version   must equal CARBON_CAI_SUBMIT_DESC_V1_VERSION
//   [15:8]    desc_size_dw   descriptor size in dwords (8)
//   [31:16]   format_flags   must be 0 for v1
//   [63:32]   cmd_id
//   [127:64]  src_addr
//   [191:128] dst_addr
//   [223:192] length
//   [255:224] reserved2      must be 0
// No ports (package).
package carbon_arch_pkg;

  localparam int         CARBON_CAI_SUBMIT_DESC_V1_BYTES   = 32;
  localparam logic [7:0] CARBON_CAI_SUBMIT_DESC_V1_VERSION = 8'h01;

  localparam int CARBON_CAI_SUBMIT_DESC_V1_VERSION_LSB   = 0;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_SIZE_DW_LSB   = 8;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_FMT_FLAGS_LSB = 16;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_CMD_ID_LSB    = 32;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_SRC_ADDR_LSB  = 64;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_DST_ADDR_LSB  = 128;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_LENGTH_LSB    = 192;
  localparam int CARBON_CAI_SUBMIT_DESC_V1_RSVD2_LSB     = 224;

endpackage

// File: rtl/cai_rr_arb.sv
// cai_rr_arb
// Combinational round-robin picker: grants the first requesting channel at or
// after ptr, wrapping around.
// Ports:
//   req      in  NUM_CH       request vector
//   ptr      in  clog2+1      search start (must be < NUM_CH)
//   gnt      out NUM_CH       one-hot grant
//   gnt_idx  out clog2+1      index of the granted channel
//   gnt_any  out 1            some channel was granted
module cai_rr_arb #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [$clog2(NUM_CH):0]  ptr,
  output logic [NUM_CH-1:0]        gnt,
  output logic [$clog2(NUM_CH):0]  gnt_idx,
  output logic                     gnt_any
);

  localparam int CW = $clog2(NUM_CH) + 1;

  // Outer loop walks priority order ptr, ptr+1, ...; inner loop maps that
  // position back to a channel so every index stays a loop constant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((((int'(ptr) + i) % NUM_CH) == c) && req[c] && !gnt_any) begin
          gnt[c]  = 1'b1;
          gnt_idx = CW'(c);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cai_submit_fetch.sv
// cai_submit_fetch
// Multi-channel CAI submit-ring fetch engine. Each ring is non-empty while its
// head differs from the software tail; enabled non-empty rings are served
// round-robin, one descriptor at a time, one bus beat outstanding at a time.
// Optional build macro: CARBON_CAI_FETCH_PERF_EN adds per-channel saturating
// perf_fetched / perf_rejected counters.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ch_en                   per-channel enable
//   ring_base               per-channel ring byte base (flattened)
//   submit_tail             per-channel producer index (flattened)
//   submit_head             per-channel consumer index (flattened, registered)
//   rd_req_valid/ready/addr read request, one beat per request
//   rd_rsp_valid/data/err   read response
//   desc_valid/ready        descriptor output handshake
//   desc_data/ch/index      assembled descriptor, source channel and slot
//   desc_status             0 OK, 1 bad header, 2 bus error
//   busy                    engine not idle
//   fetch_state             current FSM state (debug)
//   perf_fetched/rejected   per-channel counters (perf build only)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, it and its payload stay stable until
// that transfer; ready may toggle freely and never depends on valid here.
module cai_submit_fetch
  import cai_fetch_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH*ADDR_W-1:0]       ring_base,
  input  logic [NUM_CH*DEPTH_LOG2-1:0]   submit_tail,
  output logic [NUM_CH*DEPTH_LOG2-1:0]   submit_head,
  output logic                           rd_req_valid,
  input  logic                           rd_req_ready,
  output logic [ADDR_W-1:0]              rd_req_addr,
  input  logic                           rd_rsp_valid,
  input  logic [DATA_W-1:0]              rd_rsp_data,
  input  logic                           rd_rsp_err,
  output logic                           desc_valid,
  input  logic                           desc_ready,
  output logic [SUBMIT_BITS-1:0]         desc_data,
  output logic [$clog2(NUM_CH):0]        desc_ch,
  output logic [DEPTH_LOG2-1:0]          desc_index,
  output logic [1:0]                     desc_status,
  output logic                           busy,
  output logic [2:0]                     fetch_state
`ifdef CARBON_CAI_FETCH_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]           perf_fetched,
  output logic [NUM_CH*32-1:0]           perf_rejected
`endif
);

  localparam int CW         = $clog2(NUM_CH) + 1;
  localparam int BEATS      = SUBMIT_BITS / DATA_W;
  localparam int BW         = $clog2(BEATS) + 1;
  localparam int BEAT_BYTES = DATA_W / 8;

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_REQ   = 3'(REQ);
  localparam logic [2:0] ST_WAIT  = 3'(WAIT);
  localparam logic [2:0] ST_CHECK = 3'(CHECK);
  localparam logic [2:0] ST_OUT   = 3'(OUT);

  logic [2:0]            state;
  logic [DEPTH_LOG2-1:0] head_q [NUM_CH];
  logic [CW-1:0]         rr_ptr;
  logic [BW-1:0]         beat;
  logic                  err_sticky;

  logic [NUM_CH-1:0]     pend;
  logic [NUM_CH-1:0]     gnt;
  logic [CW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic [DEPTH_LOG2-1:0] gnt_head;
  logic [ADDR_W-1:0]     cur_base;
  logic                  hs_desc;

  // Equality-only emptiness test; overrun is software's concern.
  always_comb begin
    pend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = ch_en[c] && (head_q[c] != submit_tail[c*DEPTH_LOG2 +: DEPTH_LOG2]);
    end
  end

  cai_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt_head = '0;
    cur_base = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) gnt_head = gnt_head | head_q[c];
      if (desc_ch == CW'(c)) cur_base = ring_base[c*ADDR_W +: ADDR_W];
    end
  end

  // desc_ch/desc_index are latched at grant, so the address is stable in REQ.
  assign rd_req_addr = cur_base
                     + ADDR_W'(desc_index) * ADDR_W'(SUBMIT_BYTES)
                     + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);

  assign rd_req_valid = (state == ST_REQ);
  assign desc_valid   = (state == ST_OUT);
  assign busy         = (state != ST_IDLE);
  assign fetch_state  = state;
  assign hs_desc      = desc_valid && desc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      beat        <= '0;
      err_sticky  <= 1'b0;
      desc_data   <= '0;
      desc_ch     <= '0;
      desc_index  <= '0;
      desc_status <= CAI_FETCH_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            desc_ch    <= gnt_idx;
            desc_index <= gnt_head;
            beat       <= '0;
            err_sticky <= 1'b0;
            desc_data  <= '0;
            rr_ptr     <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rd_rsp_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat == BW'(k)) desc_data[k*DATA_W +: DATA_W] <= rd_rsp_data;
            end
            // Error beats are still stored and the fetch continues; the
            // status reports the error once all beats are in.
            err_sticky <= err_sticky | rd_rsp_err;
            if (beat == BW'(BEATS - 1)) begin
              state <= ST_CHECK;
            end else begin
              beat  <= beat + BW'(1);
              state <= ST_REQ;
            end
          end
        end
        ST_CHECK: begin
          if (err_sticky)             desc_status <= CAI_FETCH_BUSERR;
          else if (!hdr_ok(desc_data)) desc_status <= CAI_FETCH_BADHDR;
          else                        desc_status <= CAI_FETCH_OK;
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (desc_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every consumed descriptor advances head, including rejected ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) head_q[c] <= '0;
    end else if (hs_desc) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (desc_ch == CW'(c)) head_q[c] <= head_q[c] + DEPTH_LOG2'(1);
      end
    end
  end

  always_comb begin
    submit_head = '0;
    for (int c = 0; c < NUM_CH; c++) submit_head[c*DEPTH_LOG2 +: DEPTH_LOG2] = head_q[c];
  end

`ifdef CARBON_CAI_FETCH_PERF_EN
  logic [31:0] fetched_q  [NUM_CH];
  logic [31:0] rejected_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fetched_q[c]  <= '0;
        rejected_q[c] <= '0;
      end
    end else if (hs_desc) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (desc_ch == CW'(c)) begin
          if (fetched_q[c] != 32'hFFFF_FFFF) fetched_q[c] <= fetched_q[c] + 32'd1;
          if ((desc_status != CAI_FETCH_OK) && (rejected_q[c] != 32'hFFFF_FFFF))
            rejected_q[c] <= rejected_q[c] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_fetched  = '0;
    perf_rejected = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      perf_fetched[c*32 +: 32]  = fetched_q[c];
      perf_rejected[c*32 +: 32] = rejected_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_cai_submit_fetch.sv
// tb_cai_submit_fetch
// Bench for cai_submit_fetch with NUM_CH=2, DEPTH_LOG2=2, DATA_W=64,
// ADDR_W=64. Ring 0 lives at 0x1000, ring 1 at 0x2000. A memory responder
// serves read beats one cycle after each accepted request; expected
// descriptors are queued when tails are bumped and compared on output.
module tb_cai_submit_fetch;

  localparam int NUM_CH     = 2;
  localparam int DEPTH_LOG2 = 2;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 64;
  localparam logic [63:0] BASE0 = 64'h1000;
  localparam logic [63:0] BASE1 = 64'h2000;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst_n;
  logic [1:0]   ch_en;
  logic [127:0] ring_base;
  logic [3:0]   submit_tail;
  logic [3:0]   submit_head;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [63:0]  rd_req_addr;
  logic         rd_rsp_valid;
  logic [63:0]  rd_rsp_data;
  logic         rd_rsp_err;
  logic         desc_valid;
  logic         desc_ready;
  logic [255:0] desc_data;
  logic [1:0]   desc_ch;
  logic [1:0]   desc_index;
  logic [1:0]   desc_status;
  logic         busy;
  logic [2:0]   fetch_state;
`ifdef CARBON_CAI_FETCH_PERF_EN
  logic [63:0]  perf_fetched;
  logic [63:0]  perf_rejected;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] tail_m [2];
  assign submit_tail = {tail_m[1], tail_m[0]};
  assign ring_base   = {BASE1, BASE0};

  cai_submit_fetch #(
    .NUM_CH(NUM_CH), .DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ring_base(ring_base),
    .submit_tail(submit_tail), .submit_head(submit_head),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .desc_ch(desc_ch), .desc_index(desc_index), .desc_status(desc_status),
    .busy(busy), .fetch_state(fetch_state)
`ifdef CARBON_CAI_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_rejected(perf_rejected)
`endif
  );

  // ---------------- memory model / responder ----------------
  logic [255:0] mem [2][4];
  logic [63:0]  addr_q [$];   // every accepted request address, in order
  bit           rsp_en;
  bit           rdy_rand;
  bit           err_en;
  int           err_ch, err_slot, err_beat;
  int           stale_req;

  initial begin : responder
    bit          rsp_pend;
    logic [63:0] pend_data;
    logic        pend_err;
    int          stale_done;
    int          rch;
    logic [63:0] off;
    logic [1:0]  slot;
    logic [1:0]  bt;
    rsp_pend = 0; pend_data = '0; pend_err = 0; stale_done = 0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; rd_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (stale_req != stale_done) begin
        stale_done++;
        rd_rsp_valid = 1'b1; rd_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0; rd_rsp_err = 1'b1;
      end else if (rsp_pend && rsp_en) begin
        rd_rsp_valid = 1'b1; rd_rsp_data = pend_data; rd_rsp_err = pend_err;
      end else begin
        rd_rsp_valid = 1'b0; rd_rsp_data = {$urandom, $urandom}; rd_rsp_err = 1'b0;
      end
      rsp_pend = 0;
      rd_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_n && rd_req_valid && rd_req_ready) begin
        addr_q.push_back(rd_req_addr);
        rch  = (rd_req_addr >= BASE1) ? 1 : 0;
        off  = rd_req_addr - ((rch == 1) ? BASE1 : BASE0);
        slot = off[6:5];
        bt   = off[4:3];
        pend_data = mem[rch][slot][bt*64 +: 64];
        pend_err  = err_en && (rch == err_ch) && (int'(slot) == err_slot) && (int'(bt) == err_beat);
        rsp_pend  = 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {status[1:0], ch[1:0], index[1:0], data[255:0]}
  logic [261:0] exp_q [$];
  int checks;
  int errors;

  function automatic logic [255:0] make_desc(input logic [7:0] tag);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
    d[7:0]     = 8'h01;
    d[15:8]    = 8'd8;
    d[31:16]   = 16'h0000;
    d[63:32]   = {24'h0, tag};
    d[255:224] = 32'h0;
    return d;
  endfunction

  task automatic wait_desc(input int budget, output bit ok, output int cycles);
    ok = 0; cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (desc_valid) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (submit_head !== 4'h0) begin errors++; $display("FAIL reset_head: got %h required 0", submit_head); end
    checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_req_valid: got %b required 0", rd_req_valid); end
    checks++; if (desc_valid !== 1'b0) begin errors++; $display("FAIL reset_desc_valid: got %b required 0", desc_valid); end
    checks++; if (desc_data !== 256'h0) begin errors++; $display("FAIL reset_desc_data: got %h required 0", desc_data); end
    checks++; if (desc_ch !== 2'd0) begin errors++; $display("FAIL reset_desc_ch: got %0d required 0", desc_ch); end
    checks++; if (desc_index !== 2'd0) begin errors++; $display("FAIL reset_desc_index: got %0d required 0", desc_index); end
    checks++; if (desc_status !== 2'd0) begin errors++; $display("FAIL reset_desc_status: got %0d required 0", desc_status); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_single();
    bit ok; int cyc; int n0; logic [261:0] e; logic [63:0] ea;
    rdy_rand = 0;
    ch_en = 2'b11;
    mem[0][0] = make_desc(8'h10);
    exp_q.push_back({2'd0, 2'd0, 2'd0, mem[0][0]});
    n0 = addr_q.size();
    tail_m[0] = 2'd1;
    wait_desc(40, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: desc_valid 0 after %0d cycles required 1", cyc); end
    checks++; if (cyc != 10) begin errors++; $display("FAIL single_latency: got %0d cycles required 10", cyc); end
    for (int k = 0; k < 4; k++) begin
      ea = BASE0 + 64'(8 * k);
      checks++;
      if (addr_q.size() <= n0 + k) begin errors++; $display("FAIL single_addr%0d: no request required %h", k, ea); end
      else if (addr_q[n0 + k] !== ea) begin errors++; $display("FAIL single_addr%0d: got %h required %h", k, addr_q[n0 + k], ea); end
    end
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if ({desc_status, desc_ch, desc_index, desc_data} !== e) begin
        errors++;
        $display("FAIL single_desc: got st=%0d ch=%0d idx=%0d data=%h required st=%0d ch=%0d idx=%0d data=%h",
                 desc_status, desc_ch, desc_index, desc_data, e[261:260], e[259:258], e[257:256], e[255:0]);
      end
      desc_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (desc_valid !== 1'b1 || desc_data !== e[255:0]) begin errors++; $display("FAIL single_hold: valid=%b data=%h required valid=1 data=%h", desc_valid, desc_data, e[255:0]); end
      checks++; if (submit_head[1:0] !== 2'd0) begin errors++; $display("FAIL single_head_before: got %0d required 0", submit_head[1:0]); end
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
      checks++; if (submit_head[1:0] !== 2'd1) begin errors++; $display("FAIL single_head_after: got %0d required 1", submit_head[1:0]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
    end
  endtask

  task automatic test_bad_header();
    bit ok; int cyc; logic [261:0] e;
    rdy_rand = 1;
    mem[0][1] = make_desc(8'h21);
    mem[0][1][31:16] = 16'h0001;
    mem[0][2] = make_desc(8'h22);
    mem[0][2][255:224] = 32'hDEAD_BEEF;
    exp_q.push_back({2'd1, 2'd0, 2'd1, mem[0][1]});
    exp_q.push_back({2'd1, 2'd0, 2'd2, mem[0][2]});
    tail_m[0] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      wait_desc(200, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL badhdr%0d_timeout: desc_valid 0 required 1", i); end
      if (ok) begin
        e = exp_q.pop_front();
        checks++;
        if ({desc_status, desc_ch, desc_index, desc_data} !== e) begin
          errors++;
          $display("FAIL badhdr%0d_desc: got st=%0d ch=%0d idx=%0d data=%h required st=%0d ch=%0d idx=%0d data=%h",
                   i, desc_status, desc_ch, desc_index, desc_data, e[261:260], e[259:258], e[257:256], e[255:0]);
        end
        desc_ready = 1'b1;
        @(negedge clk);
        desc_ready = 1'b0;
        checks++; if (submit_head[1:0] !== 2'(2 + i)) begin errors++; $display("FAIL badhdr%0d_head: got %0d required %0d", i, submit_head[1:0], 2 + i); end
      end
    end
  endtask

  task automatic test_bus_error();
    bit ok; int cyc; int n0; logic [261:0] e; logic [63:0] ea;
    mem[1][0] = make_desc(8'h30);
    err_en = 1; err_ch = 1; err_slot = 0; err_beat = 1;
    exp_q.push_back({2'd2, 2'd1, 2'd0, mem[1][0]});
    n0 = addr_q.size();
    tail_m[1] = 2'd1;
    wait_desc(200, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL buserr_timeout: desc_valid 0 required 1"); end
    checks++; if (addr_q.size() != n0 + 4) begin errors++; $display("FAIL buserr_beats: got %0d requests required 4", addr_q.size() - n0); end
    for (int k = 0; k < 4; k++) begin
      ea = BASE1 + 64'(8 * k);
      checks++;
      if (addr_q.size() <= n0 + k) begin errors++; $display("FAIL buserr_addr%0d: no request required %h", k, ea); end
      else if (addr_q[n0 + k] !== ea) begin errors++; $display("FAIL buserr_addr%0d: got %h required %h", k, addr_q[n0 + k], ea); end
    end
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if ({desc_status, desc_ch, desc_index, desc_data} !== e) begin
        errors++;
        $display("FAIL buserr_desc: got st=%0d ch=%0d idx=%0d data=%h required st=%0d ch=%0d idx=%0d data=%h",
                 desc_status, desc_ch, desc_index, desc_data, e[261:260], e[259:258], e[257:256], e[255:0]);
      end
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
      checks++; if (submit_head[3:2] !== 2'd1) begin errors++; $display("FAIL buserr_head: got %0d required 1", submit_head[3:2]); end
    end
    err_en = 0;
  endtask

  task automatic test_wrap();
    bit ok; int cyc; int n0; logic [261:0] e;
    mem[0][3] = make_desc(8'h43);
    exp_q.push_back({2'd0, 2'd0, 2'd3, mem[0][3]});
    n0 = addr_q.size();
    tail_m[0] = 2'd0;
    wait_desc(200, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: desc_valid 0 required 1"); end
    checks++;
    if (addr_q.size() <= n0) begin errors++; $display("FAIL wrap_addr: no request required %h", BASE0 + 64'h60); end
    else if (addr_q[n0] !== BASE0 + 64'h60) begin errors++; $display("FAIL wrap_addr: got %h required %h", addr_q[n0], BASE0 + 64'h60); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if ({desc_status, desc_ch, desc_index, desc_data} !== e) begin
        errors++;
        $display("FAIL wrap_desc: got st=%0d ch=%0d idx=%0d data=%h required st=%0d ch=%0d idx=%0d data=%h",
                 desc_status, desc_ch, desc_index, desc_data, e[261:260], e[259:258], e[257:256], e[255:0]);
      end
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
      checks++; if (submit_head[1:0] !== 2'd0) begin errors++; $display("FAIL wrap_head: got %0d required 0", submit_head[1:0]); end
    end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: busy=%b required 0", busy); end
    checks++; if (addr_q.size() != n0 + 4) begin errors++; $display("FAIL wrap_reqs: got %0d requests required 4", addr_q.size() - n0); end
  endtask

  task automatic test_round_robin();
    bit ok; int cyc; logic [261:0] e;
    // Fresh start so heads and the rr pointer are back at 0.
    rst_n = 1'b0; ch_en = 2'b00; tail_m[0] = 2'd0; tail_m[1] = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) mem[0][s] = make_desc(8'(8'h50 + s));
    for (int s = 0; s < 2; s++) mem[1][s] = make_desc(8'(8'h60 + s));
    exp_q.push_back({2'd0, 2'd0, 2'd0, mem[0][0]});
    exp_q.push_back({2'd0, 2'd1, 2'd0, mem[1][0]});
    exp_q.push_back({2'd0, 2'd0, 2'd1, mem[0][1]});
    exp_q.push_back({2'd0, 2'd1, 2'd1, mem[1][1]});
    exp_q.push_back({2'd0, 2'd0, 2'd2, mem[0][2]});
    ch_en = 2'b11;
    tail_m[0] = 2'd3;
    tail_m[1] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      wait_desc(200, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL rr%0d_timeout: desc_valid 0 required 1", i); end
      if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if ({desc_status, desc_ch, desc_index, desc_data} !== e) begin
        errors++;
        $display("FAIL rr%0d_desc: got st=%0d ch=%0d idx=%0d data=%h required st=%0d ch=%0d idx=%0d data=%h",
                 i, desc_status, desc_ch, desc_index, desc_data, e[261:260], e[259:258], e[257:256], e[255:0]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
    end
    checks++; if (submit_head !== {2'd2, 2'd3}) begin errors++; $display("FAIL rr_heads: got %h required %h", submit_head, {2'd2, 2'd3}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_leftover: got %0d queued required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_fetch();
    int n0; int cyc; bit seen_valid; bit seen_req;
    rsp_en = 0;
    mem[0][3] = make_desc(8'h73);
    n0 = addr_q.size();
    tail_m[0] = 2'd0;   // head0 is 3: one pending descriptor
    cyc = 0;
    while (addr_q.size() == n0 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (addr_q.size() == n0) begin errors++; $display("FAIL midrst_req: got no request required 1"); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rd_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_wait: busy=%b rd_req_valid=%b required 1 0", busy, rd_req_valid); end
    rst_n = 1'b0;
    ch_en = 2'b00;
    tail_m[0] = 2'd1;
    tail_m[1] = 2'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale_req++;
    n0 = addr_q.size();
    seen_valid = 0; seen_req = 0;
    repeat (30) begin
      @(negedge clk);
      if (desc_valid) seen_valid = 1;
      if (rd_req_valid) seen_req = 1;
    end
    checks++; if (seen_valid) begin errors++; $display("FAIL midrst_desc_valid: got 1 required 0"); end
    checks++; if (seen_req || addr_q.size() != n0) begin errors++; $display("FAIL midrst_no_req: got %0d requests required 0", addr_q.size() - n0); end
    checks++; if (submit_head !== 4'h0) begin errors++; $display("FAIL midrst_heads: got %h required 0", submit_head); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (desc_data !== 256'h0) begin errors++; $display("FAIL midrst_data: got %h required 0", desc_data); end
    rsp_en = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    checks = 0; errors = 0;
    rst_n = 1'b0; ch_en = 2'b00; desc_ready = 1'b0;
    tail_m[0] = 2'd0; tail_m[1] = 2'd0;
    rsp_en = 1; rdy_rand = 0; err_en = 0; err_ch = 0; err_slot = 0; err_beat = 0; stale_req = 0;
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 4; s++) mem[c][s] = make_desc(8'(c * 16 + s));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_bad_header();
    test_bus_error();
    test_wrap();
    test_round_robin();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
